// File: rtl/data_mem_arb.sv
// data_mem_arb: round-robin arbiter in front of a byte-enabled data RAM.
// Reads return the full word RD_LAT cycles after accept with no backpressure;
// writes are silent unless range checking flags them.
// Optional feature: define DATA_MEM_ARB_RANGE_CHK_EN to flag word indexes
// >= MEM_WORDS with rsp_err (writes suppressed); otherwise indexes alias
// modulo MEM_WORDS.
module data_mem_arb #(
    parameter int NCH       = 2,
    parameter int DM_AW     = 10,
    parameter int DM_DW     = 32,
    parameter int MEM_WORDS = 192,
    parameter int RD_LAT    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCH-1:0]             req_vld,
    output logic [NCH-1:0]             req_rdy,
    input  logic [NCH-1:0]             req_wr,
    input  logic [NCH*(DM_DW/8)-1:0]   req_be,
    input  logic [NCH*DM_AW-1:0]       req_addr,
    input  logic [NCH*DM_DW-1:0]       req_wdata,
    output logic [NCH-1:0]             rsp_vld,
    output logic [DM_DW-1:0]           rsp_rdata,
    output logic                       rsp_err
);
    localparam int NB = DM_DW / 8;
    localparam int WL = $clog2(NB);
    localparam int MA = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    gsel;
    logic [NCH-1:0]   grant;
    logic             acc;
    logic             sel_wr;
    logic [NB-1:0]    sel_be;
    logic [DM_AW-1:0] sel_addr;
    logic [DM_DW-1:0] sel_wdata;
    logic [31:0]      word;
    logic             oor;
    logic [MA-1:0]    maddr;
    logic             rsp_go;

    logic [DM_DW-1:0] mem [MEM_WORDS];

    logic [NCH-1:0]   vld_pipe [RD_LAT];
    logic [DM_DW-1:0] dat_pipe [RD_LAT];
    logic             err_pipe [RD_LAT];

    // Round-robin scan starting at rr_ptr; first valid channel wins.
    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        gsel  = '0;
        acc   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            c = (int'(rr_ptr) + k) % NCH;
            if (!acc && req_vld[c]) begin
                acc      = 1'b1;
                grant[c] = 1'b1;
                gsel     = PW'(c);
            end
        end
        if (rst) begin
            grant = '0;
            acc   = 1'b0;
        end
    end

    assign req_rdy = grant;

    // Mux the granted channel's request fields (grant is one-hot or zero).
    always_comb begin
        sel_wr    = 1'b0;
        sel_be    = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                sel_wr    = req_wr[i];
                sel_be    = req_be[i*NB +: NB];
                sel_addr  = req_addr[i*DM_AW +: DM_AW];
                sel_wdata = req_wdata[i*DM_DW +: DM_DW];
            end
        end
    end

    // Word index from the byte address; low lane bits are ignored.
    always_comb begin
        word = 32'(sel_addr >> WL);
`ifdef DATA_MEM_ARB_RANGE_CHK_EN
        oor   = (word >= 32'(MEM_WORDS));
        maddr = MA'(word);
`else
        oor   = 1'b0;
        maddr = MA'(word % 32'(MEM_WORDS));
`endif
    end

    // Reads always respond; writes respond only when flagged out of range.
    assign rsp_go = acc && (!sel_wr || oor);

    // Pointer moves past the granted channel on every accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_ptr <= '0;
        else if (acc)
            rr_ptr <= (gsel == PW'(NCH - 1)) ? '0 : gsel + 1'b1;
    end

    // RAM write with per-lane enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (acc && sel_wr && !oor)
            for (int b = 0; b < NB; b++)
                if (sel_be[b])
                    mem[maddr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
    end

    // Response shift register; reset drops every in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                vld_pipe[s] <= '0;
                dat_pipe[s] <= '0;
                err_pipe[s] <= 1'b0;
            end
        end else begin
            vld_pipe[0] <= rsp_go ? grant : '0;
            dat_pipe[0] <= (rsp_go && !oor) ? mem[maddr] : '0;
            err_pipe[0] <= rsp_go && oor;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                dat_pipe[s] <= dat_pipe[s-1];
                err_pipe[s] <= err_pipe[s-1];
            end
        end
    end

    assign rsp_vld   = vld_pipe[RD_LAT-1];
    assign rsp_rdata = (|rsp_vld) ? dat_pipe[RD_LAT-1] : '0;
    assign rsp_err   = (|rsp_vld) ? err_pipe[RD_LAT-1] : 1'b0;

endmodule
